// File: rtl/bc_buffer_dual.sv
// bc_buffer_dual: two independent synchronous FIFOs sharing one clock and reset.
// Channel 0 is the incoming FIFO (link -> core). Channel 1 is the outgoing FIFO
// (core -> link/SERDES). Read data is registered: a word popped at one rising edge
// appears on from_* after that edge. There is no first-word fall-through.
// Status flags come only from the registered occupancy count, so no input reaches
// an output through combinational logic.
// DEPTH must be a power of two and at least 2, so that the pointers wrap for free.

module bc_buffer_dual #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_wr_en,
    input  logic              in_rd_en,
    input  logic              out_wr_en,
    input  logic              out_rd_en,
    input  logic [DATA_W-1:0] to_incoming,
    input  logic [DATA_W-1:0] to_outgoing,
    output logic [DATA_W-1:0] from_incoming,
    output logic [DATA_W-1:0] from_outgoing,
    output logic              in_full,
    output logic              in_empty,
    output logic              out_full,
    output logic              out_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Per-channel views of the ports: index 0 = incoming, index 1 = outgoing.
    logic [1:0]             w_wr_en;
    logic [1:0]             w_rd_en;
    logic [1:0][DATA_W-1:0] w_wdata;
    logic [1:0][DATA_W-1:0] w_rdata;
    logic [1:0]             w_full;
    logic [1:0]             w_empty;

    assign w_wr_en = {out_wr_en, in_wr_en};
    assign w_rd_en = {out_rd_en, in_rd_en};
    assign w_wdata = {to_outgoing, to_incoming};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [AW-1:0]     r_wptr;
        logic [AW-1:0]     r_rptr;
        logic [CW-1:0]     r_count;
        logic [DATA_W-1:0] r_rdata;
        logic              w_push;
        logic              w_pop;
        logic              w_is_full;
        logic              w_is_empty;

        assign w_is_full  = (r_count == CNT_FULL);
        assign w_is_empty = (r_count == '0);

        // Acceptance uses the flags as they were before the edge. When the FIFO is
        // empty, a read is ignored, so a word written in the same cycle is not
        // forwarded to the output.
        assign w_push = w_wr_en[g] && !w_is_full;
        assign w_pop  = w_rd_en[g] && !w_is_empty;

        // Storage array; its contents are deliberately not cleared by reset.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= w_wdata[g];
            end
        end

        // Pointers, occupancy count and registered read data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_rdata <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr  <= r_rptr + PTR_ONE;
                    r_rdata <= r_mem[r_rptr];
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end

        assign w_rdata[g] = r_rdata;
        assign w_full[g]  = w_is_full;
        assign w_empty[g] = w_is_empty;
    end

    assign from_incoming = w_rdata[0];
    assign from_outgoing = w_rdata[1];
    assign in_full       = w_full[0];
    assign in_empty      = w_empty[0];
    assign out_full      = w_full[1];
    assign out_empty     = w_empty[1];

endmodule

// File: tb/tb_bc_buffer_dual.sv
// Scoreboard bench for bc_buffer_dual.
// The driver applies one cycle of stimulus at a time and updates a queue-based
// model of both FIFOs. For each cycle it pushes the expected outputs into a
// scoreboard queue. A separate monitor pops that queue at each falling edge and
// compares the DUT outputs against it.

module tb_bc_buffer_dual;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          in_wr_en;
    logic          in_rd_en;
    logic          out_wr_en;
    logic          out_rd_en;
    logic [DW-1:0] to_incoming;
    logic [DW-1:0] to_outgoing;
    logic [DW-1:0] from_incoming;
    logic [DW-1:0] from_outgoing;
    logic          in_full;
    logic          in_empty;
    logic          out_full;
    logic          out_empty;

    bc_buffer_dual #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_wr_en      (in_wr_en),
        .in_rd_en      (in_rd_en),
        .out_wr_en     (out_wr_en),
        .out_rd_en     (out_rd_en),
        .to_incoming   (to_incoming),
        .to_outgoing   (to_outgoing),
        .from_incoming (from_incoming),
        .from_outgoing (from_outgoing),
        .in_full       (in_full),
        .in_empty      (in_empty),
        .out_full      (out_full),
        .out_empty     (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] fi;
        logic [DW-1:0] fo;
        logic          ie;
        logic          ifl;
        logic          oe;
        logic          ofl;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] q_in[$];
    logic [DW-1:0] q_out[$];
    logic [DW-1:0] hold_in;
    logic [DW-1:0] hold_out;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Model of one edge for one FIFO. Acceptance is decided on the occupancy before the edge.
    task automatic model_edge(input int c, input logic wr, input logic rd, input logic [DW-1:0] d);
        int n;
        n = (c == 0) ? q_in.size() : q_out.size();
        if (rd && n > 0) begin
            if (c == 0) hold_in = q_in.pop_front();
            else        hold_out = q_out.pop_front();
        end
        if (wr && n < DEPTH) begin
            if (c == 0) q_in.push_back(d);
            else        q_out.push_back(d);
        end
    endtask

    task automatic step(input logic iw, input logic ir, input logic [DW-1:0] id,
                        input logic ow, input logic orr, input logic [DW-1:0] od);
        exp_t e;
        in_wr_en    = iw;
        in_rd_en    = ir;
        to_incoming = id;
        out_wr_en   = ow;
        out_rd_en   = orr;
        to_outgoing = od;
        @(posedge clk);
        model_edge(0, iw, ir, id);
        model_edge(1, ow, orr, od);
        e.fi  = hold_in;
        e.fo  = hold_out;
        e.ie  = (q_in.size() == 0);
        e.ifl = (q_in.size() == DEPTH);
        e.oe  = (q_out.size() == 0);
        e.ofl = (q_out.size() == DEPTH);
        sb.push_back(e);
        #1;
        in_wr_en  = 1'b0;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_from_incoming"}, from_incoming, '0);
        chk({tag, "_from_outgoing"}, from_outgoing, '0);
        chk({tag, "_in_empty"}, DW'(in_empty), DW'(1));
        chk({tag, "_in_full"}, DW'(in_full), DW'(0));
        chk({tag, "_out_empty"}, DW'(out_empty), DW'(1));
        chk({tag, "_out_full"}, DW'(out_full), DW'(0));
    endtask

    // Monitor: compares the DUT outputs with the scoreboard once per cycle, at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("from_incoming", from_incoming, e.fi);
                chk("from_outgoing", from_outgoing, e.fo);
                chk("in_empty", DW'(in_empty), DW'(e.ie));
                chk("in_full", DW'(in_full), DW'(e.ifl));
                chk("out_empty", DW'(out_empty), DW'(e.oe));
                chk("out_full", DW'(out_full), DW'(e.ofl));
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_wr_en = 1'b0; in_rd_en = 1'b0; out_wr_en = 1'b0; out_rd_en = 1'b0;
        to_incoming = '0; to_outgoing = '0;
        hold_in = '0; hold_out = '0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Outgoing FIFO: fill, idle, then drain.
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, 0, DW'(10 + i));
        repeat (2) step(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 0, 1, '0);

        // Incoming FIFO: same sequence; the outgoing FIFO must stay empty.
        for (int i = 0; i < 10; i++) step(1, 0, DW'(16'hA000 + i), 0, 0, '0);
        repeat (2) step(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, 1, '0, 0, 0, '0);

        // Overflow: write 20 words into 16 entries, then read 18 times.
        for (int i = 0; i < 20; i++) step(0, 0, '0, 1, 0, DW'(i));
        for (int i = 0; i < 18; i++) step(0, 0, '0, 0, 1, '0);

        // Simultaneous read/write with pointer wrap, on both FIFOs.
        for (int i = 0; i < 3; i++) step(1, 0, DW'(200 + i), 1, 0, DW'(300 + i));
        for (int i = 0; i < 30; i++) step(1, 1, DW'(100 + i), 1, 1, DW'(100 + i));
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0, 1, '0);

        // Empty FIFO: a read and a write in the same edge. The write is accepted, and the
        // read neither pops nor forwards the new word.
        step(1, 1, DW'(16'h0055), 1, 1, DW'(16'h0055));
        step(0, 1, '0, 0, 1, '0);

        // Reset in the middle of a stream, asserted between clock edges.
        for (int i = 0; i < 5; i++) step(1, 0, DW'(16'h0E00 + i), 1, 0, DW'(16'h0F00 + i));
        step(0, 1, '0, 0, 1, '0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_state("midreset");
        q_in.delete();
        q_out.delete();
        hold_in = '0;
        hold_out = '0;
        #1 rst = 1'b0;
        step(1, 0, DW'(16'h0077), 1, 0, DW'(16'h0077));
        step(0, 1, '0, 0, 1, '0);

        // Random traffic on both FIFOs. Biased phases push the occupancy to full and
        // to empty.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 3) < 2 + (bias == 0 ? 1 : 0)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) < 2 + (bias == 1 ? 1 : 0)) ? 1'b1 : 1'b0,
                 DW'($urandom),
                 ($urandom_range(0, 3) < 2 + (bias == 2 ? 1 : 0)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) < 2 + (bias == 0 ? 1 : 0)) ? 1'b1 : 1'b0,
                 DW'($urandom));
        end

        // Let the monitor consume the last entries, with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d scoreboard entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
